// File: rtl/wb_stage_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_regfile_pkg
// Description : Shared constants and types for the writeback stage and its
//               register file. OPC_SEL_ALU_BIT is also consumed by the
//               upstream output mux to pick between the ALU result and the
//               forward choice.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_stage_regfile_pkg;

    localparam int DATA_W          = 8;
    localparam int NUM_REGS        = 4;
    localparam int ADDR_W          = 2;
    localparam int OPC_SEL_ALU_BIT = 0;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage : wb_stage_regfile_pkg
`default_nettype wire

// File: rtl/wb_stage_regfile_regfile_4x8.sv
`default_nettype none
// ============================================================================
// Module      : regfile_4x8
// Description : NUM_REGS x DATA_W register file. One synchronous write port,
//               two asynchronous read ports, no bypass (the writeback stage
//               provides it).
// Ports       : clk       - system clock, rising edge
//               rst       - synchronous active-high reset, clears all entries
//               i_we      - write enable
//               i_waddr   - write address
//               i_wdata   - write data
//               i_raddr1  - read port 1 address
//               i_raddr2  - read port 2 address
//               o_rdata1  - read port 1 data
//               o_rdata2  - read port 2 data
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_4x8
    import wb_stage_regfile_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_we,
    input  reg_addr_t i_waddr,
    input  data_t     i_wdata,
    input  reg_addr_t i_raddr1,
    input  reg_addr_t i_raddr2,
    output data_t     o_rdata1,
    output data_t     o_rdata2
);

    data_t r_regs [NUM_REGS];

    // Reset has priority over a write presented on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = r_regs[i_raddr1];
    assign o_rdata2 = r_regs[i_raddr2];

endmodule : regfile_4x8
`default_nettype wire

// File: rtl/wb_stage_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_regfile
// Description : Writeback stage. Captures the output-mux write data into an
//               EX/WB register, commits it to the register file one cycle
//               later, serves bypassed reads to decode, exports forwarding
//               info and counts retired register-file write cycles.
// Ports       : clk           - system clock, rising edge
//               reset         - synchronous active-high reset
//               ex_valid      - EX holds a valid result
//               ex_opcode     - EX opcode, bit OPC_SEL_ALU_BIT = ALU result
//               ex_rd         - EX destination register
//               write_data    - output mux result
//               stall         - freeze the EX/WB register
//               rs1/rs2_addr  - read port addresses
//               rs1/rs2_data  - bypassed read data
//               wb_valid      - EX/WB register holds a valid write
//               wb_rd         - registered destination
//               wb_data       - registered write data (forwarding source)
//               wb_is_alu     - registered ALU-select opcode bit
//               retired_count - register-file write cycles, wraps
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage_regfile
    import wb_stage_regfile_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic [1:0]       ex_opcode,
    input  reg_addr_t        ex_rd,
    input  data_t            write_data,
    input  logic             stall,
    input  reg_addr_t        rs1_addr,
    input  reg_addr_t        rs2_addr,
    output data_t            rs1_data,
    output data_t            rs2_data,
    output logic             wb_valid,
    output reg_addr_t        wb_rd,
    output data_t            wb_data,
    output logic             wb_is_alu,
    output logic [CNT_W-1:0] retired_count
);

    logic             r_wb_valid;
    reg_addr_t        r_wb_rd;
    data_t            r_wb_data;
    logic             r_wb_is_alu;
    logic [CNT_W-1:0] r_retired_count;

    data_t            w_rf_rdata1;
    data_t            w_rf_rdata2;

    // Only the ALU-select bit is captured; the rest of the opcode is unused here.
    logic             w_unused_opcode;
    assign w_unused_opcode = ^ex_opcode;

    // EX/WB register. When invalid and not stalled, only the valid bit drops;
    // the payload keeps its last value so wb_rd/wb_data stay stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
            r_wb_is_alu <= 1'b0;
        end else if (!stall) begin
            r_wb_valid <= ex_valid;
            if (ex_valid) begin
                r_wb_rd     <= ex_rd;
                r_wb_data   <= write_data;
                r_wb_is_alu <= ex_opcode[OPC_SEL_ALU_BIT];
            end
        end
    end

    // Counts write cycles, so a stalled valid entry is counted every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired_count <= '0;
        end else if (r_wb_valid) begin
            r_retired_count <= r_retired_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Commit uses the pre-edge EX/WB contents, so a new entry may load on the
    // same edge the old one retires.
    regfile_4x8 u_regfile (
        .clk      (clk),
        .rst      (reset),
        .i_we     (r_wb_valid),
        .i_waddr  (r_wb_rd),
        .i_wdata  (r_wb_data),
        .i_raddr1 (rs1_addr),
        .i_raddr2 (rs2_addr),
        .o_rdata1 (w_rf_rdata1),
        .o_rdata2 (w_rf_rdata2)
    );

    // Bypass the committing entry so it is readable in its commit cycle.
    assign rs1_data = (r_wb_valid && (rs1_addr == r_wb_rd)) ? r_wb_data : w_rf_rdata1;
    assign rs2_data = (r_wb_valid && (rs2_addr == r_wb_rd)) ? r_wb_data : w_rf_rdata2;

    assign wb_valid      = r_wb_valid;
    assign wb_rd         = r_wb_rd;
    assign wb_data       = r_wb_data;
    assign wb_is_alu     = r_wb_is_alu;
    assign retired_count = r_retired_count;

endmodule : wb_stage_regfile
`default_nettype wire

// File: tb/tb_wb_stage_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage_regfile
// Description : Self-checking bench for wb_stage_regfile. Directed table of
//               stimulus/expected records, then a reference-model driven
//               counter-wrap run and a reset-over-pending-write sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage_regfile;
    import wb_stage_regfile_pkg::*;

    typedef struct {
        logic       rst;
        logic       v;
        logic [1:0] op;
        logic [1:0] rd;
        logic [7:0] wd;
        logic       st;
        logic [1:0] a1;
        logic [1:0] a2;
    } stim_t;

    typedef struct {
        logic       valid;
        logic [1:0] rd;
        logic [7:0] data;
        logic       alu;
        logic [7:0] r1;
        logic [7:0] r2;
        logic [7:0] cnt;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       ex_valid;
    logic [1:0] ex_opcode;
    reg_addr_t  ex_rd;
    data_t      write_data;
    logic       stall;
    reg_addr_t  rs1_addr;
    reg_addr_t  rs2_addr;
    data_t      rs1_data;
    data_t      rs2_data;
    logic       wb_valid;
    reg_addr_t  wb_rd;
    data_t      wb_data;
    logic       wb_is_alu;
    logic [7:0] retired_count;

    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t sb[$];

    // Reference model state
    logic       m_valid;
    logic [1:0] m_rd;
    logic [7:0] m_data;
    logic       m_alu;
    logic [7:0] m_cnt;
    logic [7:0] m_rf [4];

    always #5 clk = ~clk;

    wb_stage_regfile #(.CNT_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_opcode     (ex_opcode),
        .ex_rd         (ex_rd),
        .write_data    (write_data),
        .stall         (stall),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .wb_is_alu     (wb_is_alu),
        .retired_count (retired_count)
    );

    function automatic vec_t mk(bit rst, bit v, int op, int rd, int wd, bit st,
                                int a1, int a2, bit ev, int erd, int ed, bit ealu,
                                int er1, int er2, int ecnt);
        vec_t r;
        r.s.rst = rst;        r.s.v  = v;          r.s.op = 2'(op);
        r.s.rd  = 2'(rd);     r.s.wd = 8'(wd);     r.s.st = st;
        r.s.a1  = 2'(a1);     r.s.a2 = 2'(a2);
        r.e.valid = ev;       r.e.rd = 2'(erd);    r.e.data = 8'(ed);
        r.e.alu   = ealu;     r.e.r1 = 8'(er1);    r.e.r2   = 8'(er2);
        r.e.cnt   = 8'(ecnt);
        return r;
    endfunction

    task automatic chk(input string tag, input string name, input logic [7:0] got,
                       input logic [7:0] exp);
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s %s: got %02h expected %02h", tag, name, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic run(input stim_t s, input exp_t e, input string tag);
        exp_t x;
        reset      = s.rst;
        ex_valid   = s.v;
        ex_opcode  = s.op;
        ex_rd      = s.rd;
        write_data = s.wd;
        stall      = s.st;
        rs1_addr   = s.a1;
        rs2_addr   = s.a2;
        sb.push_back(e);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        n_vec++;
        chk(tag, "wb_valid",  {7'd0, wb_valid},  {7'd0, x.valid});
        chk(tag, "wb_rd",     {6'd0, wb_rd},     {6'd0, x.rd});
        chk(tag, "wb_data",   wb_data,           x.data);
        chk(tag, "wb_is_alu", {7'd0, wb_is_alu}, {7'd0, x.alu});
        chk(tag, "rs1_data",  rs1_data,          x.r1);
        chk(tag, "rs2_data",  rs2_data,          x.r2);
        chk(tag, "retired",   retired_count,     x.cnt);
    endtask

    // Behavioural model: commit with pre-edge contents, then load/hold.
    task automatic model_step(input stim_t s, output exp_t e);
        if (s.rst) begin
            m_valid = 1'b0; m_rd = '0; m_data = '0; m_alu = 1'b0; m_cnt = '0;
            for (int i = 0; i < 4; i++) m_rf[i] = '0;
        end else begin
            if (m_valid) begin
                m_rf[m_rd] = m_data;
                m_cnt      = m_cnt + 8'd1;
            end
            if (!s.st) begin
                if (s.v) begin
                    m_rd   = s.rd;
                    m_data = s.wd;
                    m_alu  = s.op[0];
                end
                m_valid = s.v;
            end
        end
        e.valid = m_valid;
        e.rd    = m_rd;
        e.data  = m_data;
        e.alu   = m_alu;
        e.cnt   = m_cnt;
        e.r1    = (m_valid && s.a1 == m_rd) ? m_data : m_rf[s.a1];
        e.r2    = (m_valid && s.a2 == m_rd) ? m_data : m_rf[s.a2];
    endtask

    vec_t  tbl [16];
    stim_t s;
    exp_t  e;

    initial begin
        // rst v  op rd wd     st a1 a2 | valid rd data alu r1 r2 cnt
        tbl[0]  = mk(1,1,1,3,'hAA,0,0,1, 0,0,'h00,0,'h00,'h00,0);
        tbl[1]  = mk(1,1,1,3,'hAA,0,2,3, 0,0,'h00,0,'h00,'h00,0);
        tbl[2]  = mk(0,1,1,2,'h5A,0,2,0, 1,2,'h5A,1,'h5A,'h00,0);
        tbl[3]  = mk(0,0,0,0,'h00,0,2,2, 0,2,'h5A,1,'h5A,'h5A,1);
        tbl[4]  = mk(0,1,0,3,'hC3,0,3,3, 1,3,'hC3,0,'hC3,'hC3,1);
        tbl[5]  = mk(0,0,0,0,'h00,0,3,2, 0,3,'hC3,0,'hC3,'h5A,2);
        tbl[6]  = mk(0,1,1,1,'h11,0,1,0, 1,1,'h11,1,'h11,'h00,2);
        tbl[7]  = mk(0,1,1,1,'h22,0,1,3, 1,1,'h22,1,'h22,'hC3,3);
        tbl[8]  = mk(0,0,0,0,'h00,0,1,1, 0,1,'h22,1,'h22,'h22,4);
        tbl[9]  = mk(0,1,0,0,'h7E,0,0,1, 1,0,'h7E,0,'h7E,'h22,4);
        tbl[10] = mk(0,1,1,2,'hFF,1,0,2, 1,0,'h7E,0,'h7E,'h5A,5);
        tbl[11] = mk(0,1,1,2,'hFF,1,2,0, 1,0,'h7E,0,'h5A,'h7E,6);
        tbl[12] = mk(0,1,1,2,'hFF,1,2,0, 1,0,'h7E,0,'h5A,'h7E,7);
        tbl[13] = mk(0,0,0,0,'h00,0,0,3, 0,0,'h7E,0,'h7E,'hC3,8);
        tbl[14] = mk(0,1,1,3,'h44,1,3,1, 0,0,'h7E,0,'hC3,'h22,8);
        tbl[15] = mk(0,0,0,0,'h00,0,1,0, 0,0,'h7E,0,'h22,'h7E,8);

        for (int i = 0; i < 16; i++) begin
            run(tbl[i].s, tbl[i].e, $sformatf("vec%0d", i));
        end

        // Counter wrap: reset, then 256 back-to-back valid writes retire.
        s = '{rst:1, v:0, op:0, rd:0, wd:0, st:0, a1:0, a2:0};
        model_step(s, e);
        run(s, e, "wrap_rst");
        for (int i = 0; i < 256; i++) begin
            s.rst = 1'b0;
            s.v   = 1'b1;
            s.st  = 1'b0;
            s.op  = 2'($urandom_range(0, 3));
            s.rd  = 2'($urandom_range(0, 3));
            s.wd  = 8'($urandom_range(0, 255));
            s.a1  = 2'($urandom_range(0, 3));
            s.a2  = 2'($urandom_range(0, 3));
            model_step(s, e);
            run(s, e, $sformatf("wrap%0d", i));
        end
        s = '{rst:0, v:0, op:0, rd:0, wd:0, st:0, a1:1, a2:2};
        model_step(s, e);
        run(s, e, "wrap_end");
        n_vec++;
        chk("wrap_end", "retired_wrapped", retired_count, 8'h00);

        // Reset while a write to r1 is pending: it must be discarded.
        s = '{rst:0, v:1, op:1, rd:1, wd:'h99, st:0, a1:1, a2:0};
        model_step(s, e);
        run(s, e, "pend_load");
        run('{rst:1, v:0, op:0, rd:0, wd:0, st:1, a1:1, a2:1},
            '{valid:0, rd:0, data:0, alu:0, r1:0, r2:0, cnt:0}, "pend_rst");
        run('{rst:0, v:0, op:0, rd:0, wd:0, st:0, a1:1, a2:0},
            '{valid:0, rd:0, data:0, alu:0, r1:0, r2:0, cnt:0}, "pend_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_wb_stage_regfile
`default_nettype wire
